regfile_wb_arbiter: RTL and testbench



---
 rtl/regfile_wb_arbiter.sv | 115 +++++++++++
 tb/tb_regfile_wb_arbiter.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
// Single write-port arbiter for the 32x32 register file. Port A (ALU) normally
// wins, and port B (load/multicycle) gets forced priority after MAX_WAIT refusals.
// The pending-write scoreboard drives the decode hazard and issue_ready outputs.

module regfile_wb_sb_cell (
    input  logic clk,
    input  logic reset_n,
    input  logic set,
    input  logic clr,
    output logic q
);
    // set has priority over clear so that a same-cycle re-issue stays tracked
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)  q <= 1'b0;
        else if (set)  q <= 1'b1;
        else if (clr)  q <= 1'b0;
    end
endmodule

module regfile_wb_arbiter #(
    parameter int unsigned MAX_WAIT = 3,
    parameter int unsigned WAIT_W   = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        a_valid,
    input  logic [4:0]  a_rd,
    input  logic [31:0] a_data,
    output logic        a_ready,
    input  logic        b_valid,
    input  logic [4:0]  b_rd,
    input  logic [31:0] b_data,
    output logic        b_ready,
    input  logic        issue_valid,
    input  logic [4:0]  issue_rd,
    output logic        issue_ready,
    input  logic [4:0]  r_reg0,
    input  logic [4:0]  r_reg1,
    output logic        hazard,
    output logic [31:0] pending,
    output logic        reg_wren,
    output logic [4:0]  w_reg0,
    output logic [31:0] w_data
);
    localparam int unsigned NUM_REGS = 32;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } wb_req_t;

    wb_req_t             a_req, b_req, win_req;
    logic [WAIT_W-1:0]   wait_cnt;
    logic                b_force;
    logic                wb_xfer;
    logic                wr_vld;
    logic                issue_xfer;
    logic [NUM_REGS-1:1] sb_q;

    assign a_req = '{rd: a_rd, data: a_data};
    assign b_req = '{rd: b_rd, data: b_data};

    // Arbitration: A by default, B once it has been refused MAX_WAIT cycles in a row
    assign b_force = (wait_cnt == WAIT_W'(MAX_WAIT));
    assign a_ready = a_valid && !(b_valid && b_force);
    assign b_ready = b_valid && (!a_valid || b_force);
    assign wb_xfer = a_ready || b_ready;
    assign win_req = b_ready ? b_req : a_req;
    assign wr_vld  = wb_xfer && (win_req.rd != 5'd0);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            wait_cnt <= '0;
        else if (!b_valid || b_ready)
            wait_cnt <= '0;
        else if (!b_force)
            wait_cnt <= wait_cnt + WAIT_W'(1);
    end

    // Registered write port; select/data hold when nothing is written
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            reg_wren <= 1'b0;
            w_reg0   <= '0;
            w_data   <= '0;
        end else begin
            reg_wren <= wr_vld;
            if (wr_vld) begin
                w_reg0 <= win_req.rd;
                w_data <= win_req.data;
            end
        end
    end

    // Scoreboard: one cell per architectural register, r0 is hardwired clear
    assign issue_ready = !pending[issue_rd] || (issue_rd == 5'd0);
    assign issue_xfer  = issue_valid && issue_ready;

    for (genvar n = 1; n < NUM_REGS; n++) begin : g_sb
        regfile_wb_sb_cell u_cell (
            .clk     (clk),
            .reset_n (reset_n),
            .set     (issue_xfer && (issue_rd == 5'(n))),
            .clr     (wb_xfer && (win_req.rd == 5'(n))),
            .q       (sb_q[n])
        );
    end

    assign pending = {sb_q, 1'b0};

    // No same-cycle bypass: decode forwards the in-flight reg_wren value itself
    assign hazard = (pending[r_reg0] && (r_reg0 != 5'd0)) ||
                    (pending[r_reg1] && (r_reg1 != 5'd0));

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: a spec-level model is checked on every
// negedge, and the directed sequence adds literal expectations that pin the model.

module tb_regfile_wb_arbiter;
    localparam int MAX_WAIT = 3;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        a_valid, b_valid, issue_valid;
    logic [4:0]  a_rd, b_rd, issue_rd, r_reg0, r_reg1;
    logic [31:0] a_data, b_data;
    logic        a_ready, b_ready, issue_ready, hazard, reg_wren;
    logic [31:0] pending, w_data;
    logic [4:0]  w_reg0;

    int checks = 0;
    int errors = 0;

    regfile_wb_arbiter #(.MAX_WAIT(MAX_WAIT), .WAIT_W(4)) dut (
        .clk(clk), .reset_n(reset_n),
        .a_valid(a_valid), .a_rd(a_rd), .a_data(a_data), .a_ready(a_ready),
        .b_valid(b_valid), .b_rd(b_rd), .b_data(b_data), .b_ready(b_ready),
        .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_ready(issue_ready),
        .r_reg0(r_reg0), .r_reg1(r_reg1), .hazard(hazard), .pending(pending),
        .reg_wren(reg_wren), .w_reg0(w_reg0), .w_data(w_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h @%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit [31:0] m_pend;
    bit        m_wren, m_wknown;
    bit [4:0]  m_wreg;
    bit [31:0] m_wdata;
    int        m_refused;

    function automatic bit exp_a_ready();
        return a_valid && !(b_valid && m_refused == MAX_WAIT);
    endfunction
    function automatic bit exp_b_ready();
        return b_valid && (!a_valid || m_refused == MAX_WAIT);
    endfunction
    function automatic bit exp_issue_ready();
        return !m_pend[issue_rd] || issue_rd == 0;
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_pend = 0; m_wren = 0; m_wreg = 0; m_wdata = 0; m_wknown = 1; m_refused = 0;
        end else begin
            bit ga, gb, iss;
            bit [4:0] rd;
            bit [31:0] d;
            ga  = exp_a_ready();
            gb  = exp_b_ready();
            iss = issue_valid && exp_issue_ready();
            rd  = gb ? b_rd : a_rd;
            d   = gb ? b_data : a_data;
            m_wren = 0;
            if (ga || gb) begin
                if (rd != 0) begin
                    m_wren = 1; m_wreg = rd; m_wdata = d; m_wknown = 1;
                end else begin
                    m_wknown = 0;  // select/data after an r0 write are not pinned down
                end
                m_pend[rd] = 1'b0;
            end
            if (iss && issue_rd != 0) m_pend[issue_rd] = 1'b1;
            m_pend[0] = 1'b0;
            if (!b_valid || gb) m_refused = 0;
            else if (m_refused < MAX_WAIT) m_refused++;
        end
    end

    always @(negedge clk) begin
        if (reset_n === 1'b1) begin
            chk("a_ready", a_ready, exp_a_ready());
            chk("b_ready", b_ready, exp_b_ready());
            chk("one_grant", a_ready && b_ready, 0);
            chk("issue_ready", issue_ready, exp_issue_ready());
            chk("pending", pending, m_pend);
            chk("hazard", hazard, (m_pend[r_reg0] && r_reg0 != 0) || (m_pend[r_reg1] && r_reg1 != 0));
            chk("reg_wren", reg_wren, m_wren);
            if (m_wknown) begin
                chk("w_reg0", w_reg0, m_wreg);
                chk("w_data", w_data, m_wdata);
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic cyc();
        @(posedge clk); #1;
    endtask

    task automatic idle();
        a_valid = 0; b_valid = 0; issue_valid = 0;
    endtask

    logic exp_b_seq [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

    initial begin
        reset_n = 0; idle();
        a_rd = 0; b_rd = 0; issue_rd = 0; r_reg0 = 0; r_reg1 = 0; a_data = 0; b_data = 0;
        cyc(); cyc();
        chk("rst_wren", reg_wren, 0);
        chk("rst_pending", pending, 0);
        chk("rst_wdata", w_data, 0);
        #2 reset_n = 1;
        cyc();

        // single A transfer
        a_valid = 1; a_rd = 5; a_data = 32'hDEADBEEF;
        #1 chk("a_single_ready", a_ready, 1);
        cyc(); idle();
        chk("a_single_wren", reg_wren, 1);
        chk("a_single_wreg", w_reg0, 5);
        chk("a_single_wdata", w_data, 32'hDEADBEEF);
        cyc();
        chk("a_single_wren_off", reg_wren, 0);
        chk("a_single_hold", w_data, 32'hDEADBEEF);

        // contention: A,A,A,B,A
        a_valid = 1; a_rd = 3; a_data = 32'h0000_AAAA;
        b_valid = 1; b_rd = 9; b_data = 32'h0000_BBBB;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("cont_b_grant", b_ready, exp_b_seq[i]);
            chk("cont_a_grant", a_ready, !exp_b_seq[i]);
            cyc();
            if (i == 3) begin
                chk("cont_b_wreg", w_reg0, 9);
                chk("cont_b_wdata", w_data, 32'h0000_BBBB);
            end
        end
        idle(); cyc();

        // scoreboard set, hazard, WAW block, clear by B
        issue_valid = 1; issue_rd = 8;
        #1 chk("sb_issue_ready", issue_ready, 1);
        cyc(); idle();
        chk("sb_pending_set", pending, 32'h0000_0100);
        r_reg1 = 8;
        #1 chk("sb_hazard", hazard, 1);
        issue_valid = 1; issue_rd = 8;
        #1 chk("sb_waw_block", issue_ready, 0);
        cyc(); idle();
        chk("sb_still_pending", pending, 32'h0000_0100);
        b_valid = 1; b_rd = 8; b_data = 32'h0808_0808;
        cyc(); idle();
        chk("sb_cleared", pending, 0);
        chk("sb_hazard_clear", hazard, 0);
        chk("sb_b_wreg", w_reg0, 8);
        r_reg1 = 0;
        cyc();

        // same-cycle set and clear of r12: set wins
        issue_valid = 1; issue_rd = 12; a_valid = 1; a_rd = 12; a_data = 32'h0C0C_0C0C;
        cyc(); idle();
        chk("setclr_pending", pending, 32'h0000_1000);
        chk("setclr_wren", reg_wren, 1);
        chk("setclr_wreg", w_reg0, 12);
        // r12 already pending: the re-issue is refused, the write clears it
        issue_valid = 1; issue_rd = 12; a_valid = 1; a_rd = 12; a_data = 32'h1212_1212;
        #1 chk("setclr_blocked", issue_ready, 0);
        cyc(); idle();
        chk("setclr_cleared", pending, 0);

        // zero register
        issue_valid = 1; issue_rd = 0; a_valid = 1; a_rd = 0; a_data = 32'h0000_1234;
        #1;
        chk("zero_a_ready", a_ready, 1);
        chk("zero_issue_ready", issue_ready, 1);
        cyc(); idle();
        chk("zero_pending", pending, 0);
        chk("zero_no_wren", reg_wren, 0);
        cyc();

        // build pending=0x110 with reg_wren=1, then reset mid-cycle
        issue_valid = 1; issue_rd = 4; cyc();
        issue_rd = 8; cyc(); idle();
        r_reg0 = 4;
        #1 chk("hz_r0", hazard, 1);
        a_valid = 1; a_rd = 20; a_data = 32'h2020_2020;
        cyc(); idle();
        chk("pre_rst_pending", pending, 32'h0000_0110);
        chk("pre_rst_wren", reg_wren, 1);
        #1 reset_n = 0;
        #1;
        chk("async_rst_wren", reg_wren, 0);
        chk("async_rst_pending", pending, 0);
        chk("async_rst_wreg", w_reg0, 0);
        chk("async_rst_wdata", w_data, 0);
        chk("async_rst_hazard", hazard, 0);
        cyc();
        #2 reset_n = 1;
        cyc(); cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
